// File: rtl/servo_pkg.sv
// Shared definitions for the servo slew controller.
//   - default geometry of the angle datapath (width, limits, home position)
//   - default settle period and counter width
//   - FSM state encoding used by servo_slew_ctrl
//   - norm_step(): a zero step request is treated as one degree per frame
package servo_pkg;

   localparam int unsigned ANGLE_W_DEF       = 9;
   localparam int unsigned MAX_ANGLE_DEF     = 180;
   localparam int unsigned HOME_ANGLE_DEF    = 90;
   localparam int unsigned SETTLE_FRAMES_DEF = 25;
   localparam int unsigned SETTLE_W_DEF      = 8;
   localparam int unsigned STEP_W            = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MOVE   = 2'd1,
      S_SETTLE = 2'd2
   } servo_state_t;

   function automatic logic [STEP_W-1:0] norm_step(input logic [STEP_W-1:0] s);
      return (s == '0) ? STEP_W'(1) : s;
   endfunction

endpackage

// File: rtl/servo_step_calc.sv
// Combinational one-frame slew step.
// Moves angle toward target by at most step degrees. When the remaining
// distance fits inside one step the result lands exactly on target and
// reached is raised, so the output can never overshoot the target (and
// therefore never leaves the 0..target / target..angle range).
//
// Ports
//   angle     in   ANGLE_W  present commanded angle
//   target    in   ANGLE_W  destination angle (already clamped)
//   step      in   STEP_W   maximum move this frame (already >= 1)
//   angle_nx  out  ANGLE_W  angle after this frame's move
//   reached   out  1        target reached with this move
module servo_step_calc
   import servo_pkg::*;
#(
   parameter int unsigned ANGLE_W = ANGLE_W_DEF
)(
   input  logic [ANGLE_W-1:0] angle,
   input  logic [ANGLE_W-1:0] target,
   input  logic [STEP_W-1:0]  step,
   output logic [ANGLE_W-1:0] angle_nx,
   output logic               reached
);

   logic             up;
   logic [ANGLE_W:0] diff;
   logic [ANGLE_W:0] step_wide;
   logic [ANGLE_W-1:0] step_ang;

   always_comb begin
      up        = target > angle;
      // one extra bit so the magnitude is computed without wrap
      diff      = up ? ({1'b0, target} - {1'b0, angle})
                     : ({1'b0, angle}  - {1'b0, target});
      step_wide = {{(ANGLE_W + 1 - STEP_W){1'b0}}, step};
      step_ang  = {{(ANGLE_W - STEP_W){1'b0}}, step};
      reached   = diff <= step_wide;
      if (reached) begin
         angle_nx = target;
      end else if (up) begin
         angle_nx = angle + step_ang;
      end else begin
         angle_nx = angle - step_ang;
      end
   end

endmodule

// File: rtl/servo_slew_ctrl.sv
// Single-servo slew sequencer.
// Accepts a target angle over a valid/ready handshake, then walks angle_out
// toward it by at most one step per 20 ms frame (frame_tick), so the PWM
// compare value only ever changes on a frame boundary. After reaching the
// target it holds for SETTLE_FRAMES frames and pulses done. cmd_abort stops
// motion where it is without a done pulse. All outputs are registered.
//
// Ports
//   clk         in   1        system clock
//   clr         in   1        asynchronous active-high reset
//   frame_tick  in   1        one-cycle pulse per PWM frame
//   cmd_valid   in   1        command present
//   cmd_ready   out  1        command can be accepted (IDLE only)
//   cmd_angle   in   ANGLE_W  target angle, clamped to MAX_ANGLE
//   cmd_step    in   STEP_W   degrees per frame, 0 means 1
//   cmd_abort   in   1        stop motion at the current angle
//   angle_out   out  ANGLE_W  commanded angle to the angle decoder
//   busy        out  1        moving or settling
//   done        out  1        one-cycle pulse at end of settle
//   clamp_err   out  1        one-cycle pulse after a clamped command
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a command, cmd_ready high
// S_MOVE   | stepping angle_out toward target on each frame_tick
// S_SETTLE | holding at target, counting frames down to done
module servo_slew_ctrl
   import servo_pkg::*;
#(
   parameter int unsigned ANGLE_W       = ANGLE_W_DEF,
   parameter int unsigned MAX_ANGLE     = MAX_ANGLE_DEF,
   parameter int unsigned HOME_ANGLE    = HOME_ANGLE_DEF,
   parameter int unsigned SETTLE_FRAMES = SETTLE_FRAMES_DEF,
   parameter int unsigned SETTLE_W      = SETTLE_W_DEF
)(
   input  logic               clk,
   input  logic               clr,
   input  logic               frame_tick,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [ANGLE_W-1:0] cmd_angle,
   input  logic [STEP_W-1:0]  cmd_step,
   input  logic               cmd_abort,
   output logic [ANGLE_W-1:0] angle_out,
   output logic               busy,
   output logic               done,
   output logic               clamp_err
);

   localparam logic [ANGLE_W-1:0]  MAX_A    = ANGLE_W'(MAX_ANGLE);
   localparam logic [ANGLE_W-1:0]  HOME_A   = ANGLE_W'(HOME_ANGLE);
   localparam logic [SETTLE_W-1:0] SETTLE_N = SETTLE_W'(SETTLE_FRAMES);
   localparam logic [SETTLE_W-1:0] CNT_ONE  = SETTLE_W'(1);

   servo_state_t        state, state_nx;
   logic [ANGLE_W-1:0]  target, target_nx;
   logic [STEP_W-1:0]   step, step_nx;
   logic [SETTLE_W-1:0] cnt, cnt_nx;
   logic [ANGLE_W-1:0]  angle_nx;
   logic                done_nx;
   logic                clamp_nx;
   logic                clamped;
   logic [ANGLE_W-1:0]  target_in;
   logic [ANGLE_W-1:0]  calc_angle;
   logic                calc_reached;

   servo_step_calc #(
      .ANGLE_W (ANGLE_W)
   ) u_step_calc (
      .angle    (angle_out),
      .target   (target),
      .step     (step),
      .angle_nx (calc_angle),
      .reached  (calc_reached)
   );

   always_comb begin
      state_nx  = state;
      target_nx = target;
      step_nx   = step;
      cnt_nx    = cnt;
      angle_nx  = angle_out;
      done_nx   = 1'b0;
      clamp_nx  = 1'b0;
      clamped   = cmd_angle > MAX_A;
      target_in = clamped ? MAX_A : cmd_angle;

      case (state)
         S_IDLE: begin
            // frame_tick on the accept edge is deliberately ignored
            if (cmd_valid && cmd_ready) begin
               target_nx = target_in;
               step_nx   = norm_step(cmd_step);
               clamp_nx  = clamped;
               if (target_in == angle_out) begin
                  state_nx = S_SETTLE;
                  cnt_nx   = SETTLE_N;
               end else begin
                  state_nx = S_MOVE;
               end
            end
         end

         S_MOVE: begin
            // abort has priority over a coincident frame_tick
            if (cmd_abort) begin
               state_nx = S_IDLE;
            end else if (frame_tick) begin
               angle_nx = calc_angle;
               if (calc_reached) begin
                  state_nx = S_SETTLE;
                  cnt_nx   = SETTLE_N;
               end
            end
         end

         S_SETTLE: begin
            if (cmd_abort) begin
               state_nx = S_IDLE;
            end else if (cnt == '0) begin
               // only reachable with a zero-length settle period
               state_nx = S_IDLE;
               done_nx  = 1'b1;
            end else if (frame_tick) begin
               cnt_nx = cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state_nx = S_IDLE;
                  done_nx  = 1'b1;
               end
            end
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= S_IDLE;
         target    <= HOME_A;
         step      <= STEP_W'(1);
         cnt       <= '0;
         angle_out <= HOME_A;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         clamp_err <= 1'b0;
      end else begin
         state     <= state_nx;
         target    <= target_nx;
         step      <= step_nx;
         cnt       <= cnt_nx;
         angle_out <= angle_nx;
         cmd_ready <= (state_nx == S_IDLE);
         busy      <= (state_nx != S_IDLE);
         done      <= done_nx;
         clamp_err <= clamp_nx;
      end
   end

endmodule
